// File: rtl/irq_collect4_pkg.sv
// rtl/irq_collect4_pkg.sv - shared constants for the four-source request collector
package irq_collect4_pkg;

  localparam int NSRC  = 4;
  localparam int IDX_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

endpackage

// File: rtl/irq_collect4_if.sv
// rtl/irq_collect4_if.sv - valid/ready index handshake between collector and encoder stage
interface irq_collect4_if;
  import irq_collect4_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);

endinterface

// File: rtl/irq_collect4_prio_enc4.sv
// rtl/irq_collect4_prio_enc4.sv - 4-bit to 2-bit lowest-index-first priority encoder
module prio_enc4
  import irq_collect4_pkg::*;
(
  input  logic [NSRC-1:0]  p,
  output logic [IDX_W-1:0] idx
);

  // Bit 0 wins; an all-zero input encodes to 0 and is never presented downstream.
  always_comb begin
    idx = 2'd0;
    if (p[0])      idx = 2'd0;
    else if (p[1]) idx = 2'd1;
    else if (p[2]) idx = 2'd2;
    else if (p[3]) idx = 2'd3;
  end

endmodule

// File: rtl/irq_collect4.sv
// rtl/irq_collect4.sv - sticky request collector with prioritized valid/ready index output
module irq_collect4
  import irq_collect4_pkg::*;
#(
  parameter int OVF_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    req,
  irq_collect4_if.master     bus,
  output logic [NSRC-1:0]    pending,
  output logic [OVF_W-1:0]   ovf_cnt
);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic             hs;
  logic [NSRC-1:0]  clr;
  logic [NSRC-1:0]  rem;
  logic             loss;
  logic [IDX_W-1:0] prio_pend;
  logic [IDX_W-1:0] prio_rem;

  assign bus.out_valid = (state == ST_SERVE);
  assign bus.out_idx   = idx_q;

  assign hs   = bus.out_valid & bus.out_ready;
  assign clr  = hs ? (NSRC'(1) << bus.out_idx) : '0;
  assign rem  = pending & ~clr;
  // A request on a bit that stays pending (not being cleared this cycle) is lost.
  assign loss = |(req & pending & ~clr);

  prio_enc4 u_prio_pend (.p(pending), .idx(prio_pend));
  prio_enc4 u_prio_rem  (.p(rem),     .idx(prio_rem));

  // Sticky request bits: a new request beats the clear of the served bit.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= rem | req;
  end

  // Selection FSM: index frozen while stalled, re-selected from the remainder on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            idx_q <= prio_pend;
            state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (hs) begin
            if (|rem) idx_q <= prio_rem;
            else      state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One count per lossy cycle, held at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                                       ovf_cnt <= '0;
    else if (loss && (ovf_cnt != {OVF_W{1'b1}}))   ovf_cnt <= ovf_cnt + OVF_W'(1);
  end

endmodule

// File: tb/tb_irq_collect4.sv
// tb/tb_irq_collect4.sv - self-checking bench for irq_collect4 with a behavioural model
module tb_irq_collect4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] pending;
  logic [7:0] ovf_cnt;

  irq_collect4_if bus ();

  irq_collect4 #(.OVF_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bus     (bus),
    .pending (pending),
    .ovf_cnt (ovf_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit [3:0] m_pend  = 4'd0;
  bit       m_valid = 1'b0;
  bit [1:0] m_idx   = 2'd0;
  int       m_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [1:0] lowest(input bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_edge(input bit r, input bit [3:0] q, input bit rdy);
    bit [3:0] clrm;
    bit [3:0] rest;
    bit       lost;
    if (r) begin
      m_pend = 0; m_valid = 0; m_idx = 0; m_cnt = 0;
    end else begin
      clrm = (m_valid && rdy) ? (4'd1 << m_idx) : 4'd0;
      rest = m_pend & ~clrm;
      lost = (q & m_pend & ~clrm) != 0;
      if (!m_valid) begin
        if (m_pend != 0) begin m_valid = 1; m_idx = lowest(m_pend); end
      end else if (rdy) begin
        if (rest != 0) m_idx = lowest(rest);
        else m_valid = 0;
      end
      m_pend = rest | q;
      if (lost && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic rdy);
    rst = r; req = q; bus.out_ready = rdy;
    @(posedge clk);
    model_edge(r, q, rdy);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset pending: got %b want 0000", pending); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_idx !== 2'd0) begin n_fail++; $display("FAIL reset idx: got %0d want 0", bus.out_idx); end
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset ovf_cnt: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_single;
    int seen;
    step(1'b0, 4'b0100, 1'b1);
    n_cmp++; if (pending !== 4'b0100 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single t+1: pending %b valid %b want 0100/0", pending, bus.out_valid); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2) begin n_fail++; $display("FAIL single t+2: valid %b idx %0d want 1/2", bus.out_valid, bus.out_idx); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0000, 1'b1);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL single one-shot: extra valid cycles %0d want 0", seen); end
    n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single drain: pending %b want 0000", pending); end
  endtask

  task automatic test_priority_stall;
    step(1'b0, 4'b1010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1) begin n_fail++; $display("FAIL prio select: valid %b idx %0d want 1/1", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    n_cmp++; if (bus.out_idx !== 2'd1 || pending !== 4'b1011) begin n_fail++; $display("FAIL prio frozen: idx %0d pending %b want 1/1011", bus.out_idx, pending); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0) begin n_fail++; $display("FAIL prio b2b second: valid %b idx %0d want 1/0", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd3) begin n_fail++; $display("FAIL prio b2b third: valid %b idx %0d want 1/3", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL prio drained: valid %b pending %b want 0/0000", bus.out_valid, pending); end
  endtask

  task automatic test_set_beats_clear;
    logic [7:0] cnt0;
    cnt0 = ovf_cnt;
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2) begin n_fail++; $display("FAIL sbc select: valid %b idx %0d want 1/2", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0100, 1'b1);
    n_cmp++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL sbc pending: got %b want 0100", pending); end
    n_cmp++; if (ovf_cnt !== cnt0) begin n_fail++; $display("FAIL sbc ovf_cnt: got %0d want %0d", ovf_cnt, cnt0); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2) begin n_fail++; $display("FAIL sbc redeliver: valid %b idx %0d want 1/2", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL sbc drained: valid %b pending %b want 0/0000", bus.out_valid, pending); end
  endtask

  task automatic test_overflow;
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b0, 4'b1000, 1'b0);
      if (i == 254) begin
        n_cmp++; if (ovf_cnt !== 8'd254) begin n_fail++; $display("FAIL ovf count254: got %0d want 254", ovf_cnt); end
      end
      if (i == 255) begin
        n_cmp++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovf count255: got %0d want 255", ovf_cnt); end
      end
    end
    n_cmp++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovf saturate: got %0d want 255", ovf_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd3) begin n_fail++; $display("FAIL ovf stall: valid %b idx %0d want 1/3", bus.out_valid, bus.out_idx); end
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0 || ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovf drain: valid %b cnt %0d want 0/255", bus.out_valid, ovf_cnt); end
  endtask

  task automatic test_reset_mid_serve;
    int seen;
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 || pending !== 4'b0011) begin n_fail++; $display("FAIL rms setup: valid %b idx %0d pending %b want 1/0/0011", bus.out_valid, bus.out_idx, pending); end
    step(1'b1, 4'b0000, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0 || pending !== 4'd0 || ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rms reset: valid %b pending %b cnt %0d want 0/0000/0", bus.out_valid, pending, ovf_cnt); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0000, 1'b1);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rms no delivery: valid cycles %0d want 0", seen); end
  endtask

  task automatic test_random;
    logic       r;
    logic [3:0] q;
    logic       rdy;
    int         bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      q   = 4'($urandom & $urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, q, rdy);
      n_cmp++; if (pending !== m_pend) begin n_fail++; bad++; if (bad < 10) $display("FAIL rand pending cyc %0d: got %b want %b", i, pending, m_pend); end
      n_cmp++; if (bus.out_valid !== m_valid) begin n_fail++; bad++; if (bad < 10) $display("FAIL rand valid cyc %0d: got %b want %b", i, bus.out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (bus.out_idx !== m_idx) begin n_fail++; bad++; if (bad < 10) $display("FAIL rand idx cyc %0d: got %0d want %0d", i, bus.out_idx, m_idx); end
      end
      n_cmp++; if (ovf_cnt !== 8'(m_cnt)) begin n_fail++; bad++; if (bad < 10) $display("FAIL rand ovf_cnt cyc %0d: got %0d want %0d", i, ovf_cnt, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'd0;
    bus.out_ready = 1'b0;
    test_reset;
    test_single;
    test_priority_stall;
    test_set_beats_clear;
    test_overflow;
    test_reset_mid_serve;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
